// File: rtl/dehaze_seq_ctrl.sv
// Frame sequencer for the dehazer datapath: pixel-tick generation, image
// memory walk, window buffer strobes, window-centre tagging and output
// latency tracking, all on one clock with a clock-enable tick.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FILL  | reading pixels, window buffer not yet holding a full window
// S_RUN   | reading pixels and producing window centres
// S_DRAIN | memory exhausted, shifting zero padding to finish the windows
// S_FLUSH | waiting for the algorithm pipeline to deliver the last pixel
// S_DONE  | one-cycle end-of-frame pulse
module dehaze_seq_ctrl #(
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int ADDR_W   = 14,
    parameter int CLK_DIV  = 4,
    parameter int WIN      = 3,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       hold,
    output logic                       tick,
    output logic                       mem_en,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       buf_shift,
    output logic                       buf_pad,
    output logic                       win_valid,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic                       alg_en,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int HALF  = WIN / 2;
    localparam int N     = IMG_W * IMG_H;
    localparam int F     = IMG_W * HALF + HALF;
    localparam int TOTAL = N + F + PIPE_LAT;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW    = $clog2(N + 1);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);

    localparam logic [TW-1:0] T_F    = TW'(F);
    localparam logic [TW-1:0] T_F1   = TW'(F - 1);
    localparam logic [TW-1:0] T_N    = TW'(N);
    localparam logic [TW-1:0] T_N1   = TW'(N - 1);
    localparam logic [TW-1:0] T_NF   = TW'(N + F);
    localparam logic [TW-1:0] T_NF1  = TW'(N + F - 1);
    localparam logic [TW-1:0] T_OF   = TW'(F + PIPE_LAT);
    localparam logic [TW-1:0] T_END  = TW'(TOTAL);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [OW-1:0] O_LAST   = OW'(N - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_RUN, S_DRAIN, S_FLUSH, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   div_cnt;
    logic [TW-1:0]   t_cnt;
    logic [OW-1:0]   out_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0]   wr_row, s1_row;
    logic [CW-1:0]   wr_col, s1_col;
    logic            s1_win, s1_out;
    logic            active, tick_en, accept, win_tick, out_tick;

    // Tick generation and read strobes; ticks stop once the frame's quota is used.
    always_comb begin
        active   = (state != S_IDLE) && (state != S_DONE);
        tick_en  = active && (t_cnt != T_END);
        tick     = tick_en && !hold && (div_cnt == DIV_LAST);
        mem_en   = tick && (t_cnt < T_N);
        mem_addr = mem_en ? ADDR_W'(t_cnt) : addr_q;
        busy     = active;
        done     = (state == S_DONE);
        accept   = (state == S_IDLE) && start;
        win_tick = tick && (t_cnt >= T_F) && (t_cnt < T_NF);
        out_tick = tick && (t_cnt >= T_OF);
    end

    // Next-state logic driven by tick index and delivered output count.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FILL;
            S_FILL:  if (tick && t_cnt == T_F1) state_nx = S_RUN;
            S_RUN:   if (tick && t_cnt == T_N1) state_nx = S_DRAIN;
            S_DRAIN: if (tick && t_cnt == T_NF1) state_nx = S_FLUSH;
            S_FLUSH: if (out_valid && out_cnt == O_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Divider, tick index, read address, output count and centre coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            t_cnt   <= '0;
            out_cnt <= '0;
            addr_q  <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else if (accept) begin
            div_cnt <= '0;
            t_cnt   <= '0;
            out_cnt <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else begin
            if (tick_en && !hold)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            if (tick)
                t_cnt <= t_cnt + TW'(1);
            if (mem_en)
                addr_q <= ADDR_W'(t_cnt);
            if (out_valid)
                out_cnt <= out_cnt + OW'(1);
            if (win_tick) begin
                if (wr_col == COL_LAST) begin
                    wr_col <= '0;
                    wr_row <= wr_row + RW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
        end
    end

    // Two-stage strobe pipeline; runs every clk so hold never cancels a strobe in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_shift <= 1'b0;
            buf_pad   <= 1'b0;
            s1_win    <= 1'b0;
            s1_out    <= 1'b0;
            s1_row    <= '0;
            s1_col    <= '0;
            win_valid <= 1'b0;
            out_valid <= 1'b0;
            row       <= '0;
            col       <= '0;
            alg_en    <= 1'b0;
        end else begin
            buf_shift <= tick && (t_cnt < T_NF);
            buf_pad   <= tick && (t_cnt >= T_N) && (t_cnt < T_NF);
            s1_win    <= win_tick;
            s1_out    <= out_tick;
            if (win_tick) begin
                s1_row <= wr_row;
                s1_col <= wr_col;
            end
            win_valid <= s1_win;
            out_valid <= s1_out;
            if (s1_win) begin
                row <= s1_row;
                col <= s1_col;
            end
            if (state_nx == S_DONE)
                alg_en <= 1'b0;
            else if (s1_win)
                alg_en <= 1'b1;
        end
    end

endmodule
